// File: rtl/uart_tx_serializer.sv
// UART transmit serialiser: takes one byte per rising edge of tx_start and sends
// a start bit, 8 data bits LSB first, optional parity and 1 or 2 stop bits.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       tx_busy,
  output logic       tx_serial
);

  // Handshake: a frame starts on a 0->1 transition of tx_start seen while idle,
  // tx_data is captured in that same cycle; tx_busy covers START..DONE and
  // tx_done pulses for exactly one cycle once the last stop bit has been sent.
  // Edges that arrive while busy are dropped, never queued.

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic          PAR_EN    = (PARITY_EN != 0);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          par_bit;
  logic          tx_start_q;
  logic          start_evt;
  logic          bit_end;

  assign start_evt = (state == ST_IDLE) && tx_start && !tx_start_q;
  assign bit_end   = (baud_cnt == BAUD_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      tx_start_q <= 1'b0;
      tx_serial  <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_start_q <= tx_start;
      case (state)
        ST_IDLE: begin
          tx_serial <= 1'b1;
          tx_busy   <= 1'b0;
          tx_done   <= 1'b0;
          baud_cnt  <= '0;
          bit_idx   <= '0;
          if (start_evt) begin
            shift_reg <= tx_data;
            // Parity is taken from the byte as latched, since the shifter empties.
            par_bit   <= (^tx_data) ^ PAR_ODD;
            state     <= ST_START;
            tx_serial <= 1'b0;
            tx_busy   <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            state     <= ST_DATA;
            tx_serial <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              if (PAR_EN) begin
                state     <= ST_PARITY;
                tx_serial <= par_bit;
              end else begin
                state     <= ST_STOP;
                tx_serial <= 1'b1;
              end
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              tx_serial <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            state     <= ST_STOP;
            tx_serial <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          tx_serial <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            // bit_idx counts stop bits here so one counter serves both phases.
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              state   <= ST_DONE;
              tx_done <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          tx_done   <= 1'b0;
          tx_busy   <= 1'b0;
          tx_serial <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          tx_done   <= 1'b0;
          tx_busy   <= 1'b0;
          tx_serial <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four instances (plain, even parity, odd parity,
// two stop bits) at 4 clocks per bit, sharing clock, reset and stimulus.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] done_o;
  logic [3:0] busy_o;
  logic [3:0] ser_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       par_even;
    int         done_plain;
    int         done_par;
    int         done_stop2;
    logic       glitch;
  } vec_t;

  vec_t vecs[6];
  vec_t b2b[4];
  vec_t v_ff;
  vec_t v_3c;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(4)) u_plain (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(done_o[0]), .tx_busy(busy_o[0]), .tx_serial(ser_o[0]));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(done_o[1]), .tx_busy(busy_o[1]), .tx_serial(ser_o[1]));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(done_o[2]), .tx_busy(busy_o[2]), .tx_serial(ser_o[2]));
  uart_tx_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(done_o[3]), .tx_busy(busy_o[3]), .tx_serial(ser_o[3]));

  task automatic check(input string name, input int k, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, k, act, exp);
    end
  endtask

  // Expected line level in cycle k of a frame (cycle 0 = edge-detect cycle).
  function automatic logic exp_serial(input logic [7:0] d, input logic par_en,
                                      input logic p, input int k, input int done_cyc);
    int slot;
    if (k < 1 || k >= done_cyc) return 1'b1;
    slot = (k - 1) / 4;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    if (par_en && slot == 9) return p;
    return 1'b1;
  endfunction

  task automatic check_cycle(input vec_t v, input logic [3:0] mask, input int k);
    int   done_cyc;
    logic par_en;
    logic p;
    for (int d = 0; d < 4; d++) begin
      if (mask[d]) begin
        done_cyc = (d == 0) ? v.done_plain : (d == 3) ? v.done_stop2 : v.done_par;
        par_en   = (d == 1) || (d == 2);
        p        = (d == 2) ? ~v.par_even : v.par_even;
        check($sformatf("dut%0d data=%02h serial", d, v.data), k, ser_o[d],
              exp_serial(v.data, par_en, p, k, done_cyc));
        check($sformatf("dut%0d data=%02h busy", d, v.data), k, busy_o[d],
              (k >= 1 && k <= done_cyc));
        check($sformatf("dut%0d data=%02h done", d, v.data), k, done_o[d],
              (k == done_cyc));
      end
    end
  endtask

  // One idle cycle is checked, then tx_start is raised (and reset released)
  // so the following cycle is cycle 0 of the frame.
  task automatic run_frame(input vec_t v, input logic [3:0] mask, input int ncyc);
    @(negedge clk);
    check_cycle(v, mask, 0);
    rst_n    = 1'b1;
    tx_start = 1'b1;
    tx_data  = v.data;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      check_cycle(v, mask, k);
      if (k == 2) tx_data = 8'($urandom_range(0, 255));
      if (v.glitch && k == 10) tx_start = 1'b0;
      if (v.glitch && k == 11) tx_start = 1'b1;
    end
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, par_even: 1'b0, done_plain: 41, done_par: 45, done_stop2: 45, glitch: 1'b0};
    vecs[1] = '{data: 8'h07, par_even: 1'b1, done_plain: 41, done_par: 45, done_stop2: 45, glitch: 1'b0};
    vecs[2] = '{data: 8'h00, par_even: 1'b0, done_plain: 41, done_par: 45, done_stop2: 45, glitch: 1'b1};
    vecs[3] = '{data: 8'hC3, par_even: 1'b0, done_plain: 41, done_par: 45, done_stop2: 45, glitch: 1'b0};
    vecs[4] = '{data: 8'h80, par_even: 1'b1, done_plain: 41, done_par: 45, done_stop2: 45, glitch: 1'b1};
    vecs[5] = '{data: 8'h5E, par_even: 1'b1, done_plain: 41, done_par: 45, done_stop2: 45, glitch: 1'b0};
    b2b[0]  = '{data: 8'h11, par_even: 1'b0, done_plain: 41, done_par: 45, done_stop2: 45, glitch: 1'b0};
    b2b[1]  = '{data: 8'h22, par_even: 1'b0, done_plain: 41, done_par: 45, done_stop2: 45, glitch: 1'b0};
    b2b[2]  = '{data: 8'h33, par_even: 1'b0, done_plain: 41, done_par: 45, done_stop2: 45, glitch: 1'b0};
    b2b[3]  = '{data: 8'h44, par_even: 1'b0, done_plain: 41, done_par: 45, done_stop2: 45, glitch: 1'b0};
    v_ff    = '{data: 8'hFF, par_even: 1'b0, done_plain: 41, done_par: 45, done_stop2: 45, glitch: 1'b0};
    v_3c    = '{data: 8'h3C, par_even: 1'b0, done_plain: 41, done_par: 45, done_stop2: 45, glitch: 1'b0};

    rst_n    = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_cycle(vecs[0], 4'hF, 0);
    rst_n = 1'b1;

    // Whole frames on all four configurations; tx_start stays high well past
    // the done pulse, so any retrigger shows up as a line or busy error.
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i], 4'hF, 60);
      tx_start = 1'b0;
    end

    // Bridge-style traffic on the plain instance: tx_start drops in the cycle
    // after tx_done and rises one cycle later.
    for (int i = 0; i < 4; i++) begin
      run_frame(b2b[i], 4'h1, 41);
      tx_start = 1'b0;
    end
    repeat (10) @(negedge clk);

    // Reset in the middle of DATA, with tx_start held high across release.
    run_frame(v_ff, 4'hF, 20);
    rst_n    = 1'b0;
    tx_start = 1'b1;
    tx_data  = 8'h3C;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_cycle(v_3c, 4'hF, 0);
    end
    run_frame(v_3c, 4'hF, 50);
    tx_start = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit stage that sits directly downstream of the APB-to-UART bridge. It consumes the bridge's per-byte start strobe and byte, and serialises the byte onto the TX line as one 8N1 frame; parity and stop-bit count are configurable. It returns a one-cycle done pulse, which the bridge uses to advance to its next FIFO byte.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit (baud divisor); legal range ≥2; bit counter width is $clog2(CLKS_PER_BIT).
PARITY_EN, 0, 1 inserts a parity bit after D7.
PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 selects even, 1 selects odd.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock.
rst_n  input  1  reset, synchronous, active-low; clock clk.
tx_start  input  1  start request from the bridge; level signal, acted on at its rising edge only.
tx_data  input  8  byte to send; sampled in the same cycle the rising edge is detected.
tx_done  output  1  one-cycle pulse after the last stop bit completes.
tx_busy  output  1  high while a frame is in progress (START through DONE).
tx_serial  output  1  serial line; idles high.

Behaviour:
- Reset (rst_n=0 at a clk edge) forces the following, and aborts any frame in progress with no done pulse:
  - state=IDLE, tx_serial=1, tx_done=0, tx_busy=0;
  - baud counter=0, bit index=0, shift register=0, tx_start_q=0.
- Start detection: a register tx_start_q tracks tx_start.
  - A start event is tx_start=1 && tx_start_q=0 while state=IDLE.
  - tx_start already high when reset is released counts as an edge.
- Rising edges in any non-IDLE state, including DONE, are ignored and not queued.
- A level held high after a frame does not retrigger. The bridge drops tx_start in CHECK_FIFO and re-raises it in TRANSFER, giving one edge per byte.
- States:
  - IDLE: on a start event, latch tx_data into the shift register and go to START. tx_serial=0 and tx_busy=1 take effect at the next clk edge.
  - START: tx_serial=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each. Shift right at each bit boundary. Bit index wraps 7→0 on exit. Exit to PARITY if PARITY_EN=1, otherwise to STOP.
  - PARITY: tx_serial = ^data XOR PARITY_ODD for CLKS_PER_BIT cycles, then STOP.
  - STOP: tx_serial=1 for STOP_BITS*CLKS_PER_BIT cycles, then DONE.
  - DONE: one cycle with tx_done=1, tx_busy=1, tx_serial=1; then IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1 and wraps to 0 at every bit boundary. The bit boundary occurs when the counter = CLKS_PER_BIT-1.
- Frame length in cycles is F = (1 + 8 + PARITY_EN + STOP_BITS) * CLKS_PER_BIT.
  - Cycle numbering: the edge-detect cycle is cycle 0; the start bit begins in cycle 1.
  - The last stop-bit cycle is cycle F; tx_done is high in cycle F+1.
  - The earliest next start event is in cycle F+2.
- tx_data changes after the latch cycle do not affect the frame in flight.
- tx_serial is driven from a register, so the line is glitch-free.

Test Plan:
1. CLKS_PER_BIT=4, defaults otherwise; reset, then tx_start 0→1 with tx_data=0xA5.
   - Required: tx_serial bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held exactly 4 cycles, over cycles 1..40.
   - Required: tx_done high only in cycle 41; tx_busy high in cycles 1..41.
2. PARITY_EN=1, PARITY_ODD=0, tx_data=0x07.
   - Required: parity bit = 1 during cycles 37..40; tx_done in cycle 45.
   - Repeat with PARITY_ODD=1: parity bit = 0.
3. STOP_BITS=2, tx_data=0x00.
   - Required: line low for cycles 1..36, high for cycles 37..44; tx_done in cycle 45.
4. tx_start held high through and beyond the done pulse.
   - Required: exactly one frame; tx_serial stays 1 and tx_busy stays 0 afterwards.
   - Also drive an extra 0→1 edge on tx_start during DATA: it is ignored, no second frame.
5. Bridge-style back-to-back traffic: bytes 0x11, 0x22, 0x33, 0x44, with tx_start lowered for 1 cycle after each tx_done.
   - Required: four frames in order, four tx_done pulses, and idle-high gaps of ≥1 cycle between frames.
6. Assert rst_n=0 mid-DATA of byte 0xFF.
   - Required: the next clk gives tx_serial=1, tx_busy=0, and no tx_done.
   - After release, a new edge with 0x3C transmits a clean, correct frame.
